// File: rtl/stream_demux_pkg.sv
// Shared definitions for the packet-aware 1-to-2 stream demultiplexer.
package stream_demux_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROUTE_A = 2'd1,
    ROUTE_B = 2'd2
  } state_t;

  localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry FIFO skid buffer carrying {data, last}; output is the head entry.
module stream_skid_buf
  import stream_demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  output logic              not_full,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready
);

  localparam int unsigned PTR_W = $clog2(SKID_DEPTH);
  localparam int unsigned CNT_BITS = $clog2(SKID_DEPTH + 1);
  localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(SKID_DEPTH);

  logic [DATA_W-1:0]   data_mem [SKID_DEPTH];
  logic                last_mem [SKID_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_BITS-1:0] count;
  logic                do_push;
  logic                do_pop;

  always_comb begin
    not_full  = (count < FULL);
    out_valid = (count != '0);
    out_data  = data_mem[rd_ptr];
    out_last  = last_mem[rd_ptr];
    do_push   = push && not_full;
    do_pop    = out_valid && out_ready;
  end

  // Storage is cleared on reset so DATA/LAST read back as zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        data_mem[i] <= '0;
        last_mem[i] <= 1'b0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        data_mem[wr_ptr] <= push_data;
        last_mem[wr_ptr] <= push_last;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_BITS'(1);
        2'b01:   count <= count - CNT_BITS'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Packet-aware 1-to-2 stream demux: whole packets go to A or B per control on
// the first beat; each channel has a skid buffer and a packet counter.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              control,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] a_data,
  output logic              a_valid,
  output logic              a_last,
  input  logic              a_ready,
  output logic [CNT_W-1:0]  a_pkts,
  output logic [DATA_W-1:0] b_data,
  output logic              b_valid,
  output logic              b_last,
  input  logic              b_ready,
  output logic [CNT_W-1:0]  b_pkts
);

  state_t state;
  logic   dest_a;
  logic   a_not_full;
  logic   b_not_full;
  logic   fire;
  logic   push_a;
  logic   push_b;

  // In IDLE the destination follows control live; mid-packet it is latched in state.
  always_comb begin
    dest_a   = (state == IDLE) ? control : (state == ROUTE_A);
    in_ready = rst_n && (dest_a ? a_not_full : b_not_full);
    fire     = in_valid && in_ready;
    push_a   = fire && dest_a;
    push_b   = fire && !dest_a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (fire && !in_last) begin
            state <= control ? ROUTE_A : ROUTE_B;
          end
        end
        ROUTE_A, ROUTE_B: begin
          if (fire && in_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_pkts <= '0;
      b_pkts <= '0;
    end else begin
      if (push_a && in_last) a_pkts <= a_pkts + CNT_W'(1);
      if (push_b && in_last) b_pkts <= b_pkts + CNT_W'(1);
    end
  end

  stream_skid_buf #(.DATA_W(DATA_W)) u_buf_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_a),
    .push_data (in_data),
    .push_last (in_last),
    .not_full  (a_not_full),
    .out_valid (a_valid),
    .out_data  (a_data),
    .out_last  (a_last),
    .out_ready (a_ready)
  );

  stream_skid_buf #(.DATA_W(DATA_W)) u_buf_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_b),
    .push_data (in_data),
    .push_last (in_last),
    .not_full  (b_not_full),
    .out_valid (b_valid),
    .out_data  (b_data),
    .out_last  (b_last),
    .out_ready (b_ready)
  );

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux against a queue-based packet model.
module tb_stream_demux;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned VW = 1 + 2 * (2 + DW) + 2 * CW;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          control = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [DW-1:0] a_data;
  logic          a_valid;
  logic          a_last;
  logic          a_ready = 1'b0;
  logic [CW-1:0] a_pkts;
  logic [DW-1:0] b_data;
  logic          b_valid;
  logic          b_last;
  logic          b_ready = 1'b0;
  logic [CW-1:0] b_pkts;

  int unsigned errors = 0;
  int unsigned checks = 0;

  stream_demux #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .control  (control),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_last   (a_last),
    .a_ready  (a_ready),
    .a_pkts   (a_pkts),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_last   (b_last),
    .b_ready  (b_ready),
    .b_pkts   (b_pkts)
  );

  always #5 clk = ~clk;

  // Reference model: per-channel FIFOs of capacity 2, packet-in-progress flag.
  beat_t         qa[$];
  beat_t         qb[$];
  bit            m_inpkt;
  bit            m_dest_a;
  logic [CW-1:0] m_pa;
  logic [CW-1:0] m_pb;
  bit            m_fire;
  bit            m_d;

  function automatic logic exp_in_ready();
    bit d;
    d = m_inpkt ? m_dest_a : control;
    return rst_n && (d ? (qa.size() < 2) : (qb.size() < 2));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      m_inpkt  = 1'b0;
      m_dest_a = 1'b0;
      m_pa     = '0;
      m_pb     = '0;
    end else begin
      m_d    = m_inpkt ? m_dest_a : control;
      m_fire = in_valid && exp_in_ready();
      if (a_ready && qa.size() > 0) void'(qa.pop_front());
      if (b_ready && qb.size() > 0) void'(qb.pop_front());
      if (m_fire) begin
        if (m_d) qa.push_back({in_last, in_data});
        else     qb.push_back({in_last, in_data});
        if (in_last) begin
          if (m_d) m_pa = m_pa + 1'b1;
          else     m_pb = m_pb + 1'b1;
          m_inpkt = 1'b0;
        end else begin
          m_inpkt  = 1'b1;
          m_dest_a = m_d;
        end
      end
    end
  end

  function automatic logic [VW-1:0] exp_vec();
    beat_t ha, hb;
    ha = (qa.size() > 0) ? qa[0] : beat_t'(0);
    hb = (qb.size() > 0) ? qb[0] : beat_t'(0);
    return {exp_in_ready(), qa.size() > 0, ha, qb.size() > 0, hb, m_pa, m_pb};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    beat_t ha, hb;
    ha = a_valid ? beat_t'({a_last, a_data}) : beat_t'(0);
    hb = b_valid ? beat_t'({b_last, b_data}) : beat_t'(0);
    return {in_ready, a_valid, ha, b_valid, hb, a_pkts, b_pkts};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic c, input logic l,
                       input logic [DW-1:0] d, input logic ar, input logic br);
    in_valid = v;
    control  = c;
    in_last  = l;
    in_data  = d;
    a_ready  = ar;
    b_ready  = br;
    #2;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst_n    = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    step();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=0", in_ready);
    end
    checks++;
    if ({a_valid, b_valid, a_last, b_last, a_data, b_data, a_pkts, b_pkts} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b%b%b%b %h %h %h %h exp=all zero",
               a_valid, b_valid, a_last, b_last, a_data, b_data, a_pkts, b_pkts);
    end
    step();
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got=%b exp=1", in_ready);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_route_a();
    beat_t       got[$];
    bit          saw_b = 1'b0;
    int unsigned sent = 0;
    int unsigned cyc = 0;
    do_reset();
    while (sent < 4 && cyc < 40) begin
      drive(1'b1, 1'b1, sent == 3, 8'h11 + 8'(sent), 1'b1, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL route_a cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (a_valid) got.push_back({a_last, a_data});
      if (b_valid) saw_b = 1'b1;
      if (in_ready) sent++;
      step();
      cyc++;
    end
    checks++;
    if (sent != 4) begin
      errors++;
      $display("FAIL route_a_timeout sent=%0d exp=4", sent);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL route_a_drain cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (a_valid) got.push_back({a_last, a_data});
      if (b_valid) saw_b = 1'b1;
      step();
    end
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL route_a_count got=%0d exp=4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== beat_t'({i == 3, 8'h11 + 8'(i)})) begin
          errors++;
          $display("FAIL route_a_beat%0d got=%h exp=%h", i, got[i], {i == 3, 8'h11 + 8'(i)});
        end
      end
    end
    checks++;
    if (saw_b || a_pkts !== 4'd1 || b_pkts !== 4'd0) begin
      errors++;
      $display("FAIL route_a_final saw_b=%b a_pkts=%0d b_pkts=%0d exp=0 1 0", saw_b, a_pkts, b_pkts);
    end
  endtask

  task automatic test_toggle();
    logic [DW-1:0] d[3];
    beat_t         got[$];
    int unsigned   sent = 0;
    int unsigned   cyc = 0;
    logic          ctl = 1'b0;
    do_reset();
    foreach (d[i]) d[i] = DW'($urandom);
    while (sent < 3 && cyc < 40) begin
      drive(1'b1, ctl, sent == 2, d[sent], 1'b1, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL toggle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (b_valid) got.push_back({b_last, b_data});
      if (in_ready) sent++;
      ctl = ~ctl;
      step();
      cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, ctl, 1'b0, 8'h00, 1'b1, 1'b1);
      ctl = ~ctl;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL toggle_drain cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (b_valid) got.push_back({b_last, b_data});
      step();
    end
    checks++;
    if (got.size() != 3 || got[0].data !== d[0] || got[1].data !== d[1] || got[2] !== beat_t'({1'b1, d[2]})) begin
      errors++;
      $display("FAIL toggle_b_beats got_n=%0d exp_n=3", got.size());
    end
    checks++;
    if (a_pkts !== 4'd0 || b_pkts !== 4'd1) begin
      errors++;
      $display("FAIL toggle_pkts a=%0d b=%0d exp a=0 b=1", a_pkts, b_pkts);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d[5];
    beat_t         got[$];
    int unsigned   sent = 0;
    int unsigned   cyc = 0;
    logic          ar = 1'b0;
    do_reset();
    foreach (d[i]) d[i] = DW'($urandom);
    while (sent < 5 && cyc < 60) begin
      if (cyc == 6) ar = 1'b1;
      drive(1'b1, 1'b1, sent == 4, d[sent], ar, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL backpressure cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (cyc == 2 || cyc == 5) begin
        checks++;
        if (in_ready !== 1'b0 || sent != 2) begin
          errors++;
          $display("FAIL backpressure_stall cyc=%0d in_ready=%b sent=%0d exp 0 and 2", cyc, in_ready, sent);
        end
      end
      if (a_valid && a_ready) got.push_back({a_last, a_data});
      if (in_ready) sent++;
      step();
      cyc++;
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
      if (a_valid && a_ready) got.push_back({a_last, a_data});
      step();
    end
    checks++;
    if (got.size() != 5) begin
      errors++;
      $display("FAIL backpressure_count got=%0d exp=5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got[i] !== beat_t'({i == 4, d[i]})) begin
          errors++;
          $display("FAIL backpressure_beat%0d got=%h exp=%h", i, got[i], {i == 4, d[i]});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d[4];
    beat_t         ga[$];
    beat_t         gb[$];
    int unsigned   sent = 0;
    int unsigned   cyc = 0;
    do_reset();
    foreach (d[i]) d[i] = DW'($urandom);
    while (sent < 4 && cyc < 40) begin
      drive(1'b1, (sent % 2) == 0, 1'b1, d[sent], 1'b1, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (a_valid) ga.push_back({a_last, a_data});
      if (b_valid) gb.push_back({b_last, b_data});
      if (in_ready) sent++;
      step();
      cyc++;
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      if (a_valid) ga.push_back({a_last, a_data});
      if (b_valid) gb.push_back({b_last, b_data});
      step();
    end
    checks++;
    if (ga.size() != 2 || gb.size() != 2 || ga[0].data !== d[0] || ga[1].data !== d[2]
        || gb[0].data !== d[1] || gb[1].data !== d[3]) begin
      errors++;
      $display("FAIL back_to_back_routing a_n=%0d b_n=%0d exp 2 2", ga.size(), gb.size());
    end
    checks++;
    if (a_pkts !== 4'd2 || b_pkts !== 4'd2) begin
      errors++;
      $display("FAIL back_to_back_pkts a=%0d b=%0d exp 2 2", a_pkts, b_pkts);
    end
  endtask

  task automatic test_wrap();
    int unsigned sent = 0;
    int unsigned cyc = 0;
    do_reset();
    while (sent < 17 && cyc < 100) begin
      drive(1'b1, 1'b0, 1'b1, DW'($urandom), 1'b1, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (in_ready) sent++;
      step();
      cyc++;
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (b_pkts !== 4'd1 || a_pkts !== 4'd0 || sent != 17) begin
      errors++;
      $display("FAIL wrap_pkts b=%0d a=%0d sent=%0d exp b=1 a=0 sent=17", b_pkts, a_pkts, sent);
    end
  endtask

  task automatic test_reset_mid();
    beat_t       gb[$];
    bit          saw_a = 1'b0;
    int unsigned sent = 0;
    int unsigned cyc = 0;
    do_reset();
    while (sent < 2 && cyc < 20) begin
      drive(1'b1, 1'b1, 1'b0, DW'($urandom), 1'b1, 1'b1);
      if (in_ready) sent++;
      step();
      cyc++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_valid !== 1'b0 || a_pkts !== 4'd0 || a_data !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_clear a_valid=%b a_pkts=%0d a_data=%h in_ready=%b exp all 0",
               a_valid, a_pkts, a_data, in_ready);
    end
    step();
    step();
    rst_n = 1'b1;
    sent = 0;
    cyc = 0;
    while (sent < 2 && cyc < 20) begin
      drive(1'b1, sent != 0, sent == 1, 8'hC0 + 8'(sent), 1'b1, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_mid_new cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (b_valid) gb.push_back({b_last, b_data});
      if (a_valid) saw_a = 1'b1;
      if (in_ready) sent++;
      step();
      cyc++;
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
      if (b_valid) gb.push_back({b_last, b_data});
      if (a_valid) saw_a = 1'b1;
      step();
    end
    checks++;
    if (saw_a || gb.size() != 2 || b_pkts !== 4'd1 || a_pkts !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_route saw_a=%b b_n=%0d b_pkts=%0d a_pkts=%0d exp 0 2 1 0",
               saw_a, gb.size(), b_pkts, a_pkts);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 3) == 0,
            DW'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      step();
    end
    for (int cyc = 0; cyc < 6; cyc++) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_route_a();
    test_toggle();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
# stream_demux

Packet-aware 1-to-2 stream demultiplexer, the receive-side counterpart of the 2:1 select path. Accepts a byte stream with valid/ready/last framing and routes each whole packet to output channel A or B as chosen by CONTROL on the packet's first beat. Each output has a 2-entry skid buffer, and the block keeps per-channel packet counters. It sits between the transfer-interface byte stream and two downstream consumers.

## Interface
- DATA_W, default 8: data width in bits.
- CNT_W, default 16: width of the per-channel packet counters.

- CLK  in  1  system clock; all logic is on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- CONTROL  in  1  route select: 1 routes to A, 0 routes to B. Sampled only on a packet's first beat.
- IN_DATA  in  DATA_W  input data.
- IN_VALID  in  1  input beat valid.
- IN_LAST  in  1  final beat of the packet.
- IN_READY  out  1  block can accept a beat.
- A_DATA / B_DATA  out  DATA_W  channel output data.
- A_VALID / B_VALID  out  1  channel beat valid.
- A_LAST / B_LAST  out  1  channel last-beat flag.
- A_READY / B_READY  in  1  downstream ready.
- A_PKTS / B_PKTS  out  CNT_W  count of packets whose last beat was accepted into that channel.

## Operation
- A beat transfers when VALID and READY are both high at a rising CLK edge, on both sides.
- FSM states: IDLE, ROUTE_A, ROUTE_B. Reset state is IDLE.
- In IDLE, the destination is CONTROL in the same cycle.
  - If the accepted beat has IN_LAST=0, go to ROUTE_A (CONTROL=1) or ROUTE_B (CONTROL=0).
  - If the accepted beat has IN_LAST=1 (single-beat packet), stay in IDLE.
- In ROUTE_x, CONTROL is ignored. Beats go to channel x. Accepting a beat with IN_LAST=1 returns the FSM to IDLE.
- IN_READY is the not-full flag of the current destination's skid buffer. In IDLE, the destination is the one CONTROL selects that cycle.
- The non-selected channel is never written. Its buffer keeps draining independently.
- Skid buffer, per channel:
  - 2 entries of {DATA, LAST}, with a 2-bit count.
  - Not-full means count < 2.
  - VALID means count > 0.
  - Output comes from the head entry.
  - A simultaneous push and pop leaves count unchanged and preserves order.
- Packet counters: A_PKTS / B_PKTS increment when a beat with IN_LAST=1 is pushed into that channel. They wrap from 2^CNT_W−1 to 0.
- Reset (asserted at any time, including mid-packet):
  - FSM goes to IDLE and both buffers empty.
  - All VALID outputs go to 0, counters go to 0, DATA/LAST outputs go to 0.
  - In-flight packets are dropped, with no partial-packet recovery.
- A_VALID must not depend combinationally on A_READY (same for B).

## Timing
- Latency: a beat accepted at edge N appears on x_VALID/x_DATA after edge N, and may be consumed at edge N+1.
- Throughput: 1 beat/cycle per channel when downstream READY is held high.
- IN_READY depends combinationally on CONTROL only in IDLE. Otherwise it is a function of registered state.
- Backpressure: with x_READY low, channel x accepts exactly 2 beats, then IN_READY drops the cycle after the second push.
- Counters update at the same edge as the push of the last beat.
- Reset values: IN_READY=1 with RST_N high and buffers empty. All outputs listed above are 0 while RST_N is low, except IN_READY, which is 0 during reset.

## Structure
- Shared package/header holds the state encodings (IDLE=2'd0, ROUTE_A=2'd1, ROUTE_B=2'd2) and the skid depth constant (2).
- One sub-module, stream_skid_buf, parameterised on DATA_W. It is instantiated twice, once per channel. The counters and FSM stay in the top level.

## Test plan
- Route A: CONTROL=1, 4-beat packet 0x11..0x14 with LAST on 0x14, A_READY=B_READY=1 → A sees 0x11..0x14 on consecutive cycles with A_LAST on 0x14; B_VALID stays 0; A_PKTS=1.
- Mid-packet CONTROL toggle: start a 3-beat packet with CONTROL=0, then toggle CONTROL every cycle → all 3 beats on B; B_PKTS=1; A_PKTS=0.
- Backpressure: A_READY=0 and a 5-beat packet to A → 2 beats are accepted, then IN_READY=0. Raise A_READY → the remaining beats flow in order with no loss or duplication.
- Back-to-back single-beat packets: LAST=1 every beat, CONTROL=1,0,1,0 → A gets beats 1 and 3, B gets beats 2 and 4; A_PKTS=2, B_PKTS=2; FSM stays in IDLE.
- Counter wrap: CNT_W=4, 17 single-beat packets to B → B_PKTS=1.
- Reset mid-packet: assert RST_N=0 after 2 beats of a 4-beat packet to A → A_VALID=0, A_PKTS=0, FSM in IDLE. After release, a new packet with CONTROL=0 routes to B.
